// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // First set mask bit strictly after cur, wrapping modulo n; cur itself if none.
  function automatic logic [3:0] next_enabled(input logic [15:0] mask,
                                              input logic [3:0]  cur,
                                              input int          n);
    logic [3:0] res;
    logic       found;
    int         j;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if ((k <= n) && !found) begin
        j = (int'(cur) + k) % n;
        if (mask[j]) begin
          res   = 4'(j);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit data, mask and anode/segment outputs of seg_scan_ctrl.
// lzb_on exists only when SEG_SCAN_LZB_EN is defined.
interface seg_scan_ctrl_if
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS = 4
) ();

  localparam int IDXW = idx_width(N_DIGITS);

  logic                    ce;
  logic [4*N_DIGITS-1:0]   digits;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     digit_en;
`ifdef SEG_SCAN_LZB_EN
  logic                    lzb_on;
`endif
  logic [N_DIGITS-1:0]     an;
  logic [3:0]              hex;
  logic                    dp;
  logic [IDXW-1:0]         idx;
  logic                    frame_start;

  modport master (
    output ce, digits, dp_in, digit_en,
`ifdef SEG_SCAN_LZB_EN
    output lzb_on,
`endif
    input  an, hex, dp, idx, frame_start
  );

  modport slave (
    input  ce, digits, dp_in, digit_en,
`ifdef SEG_SCAN_LZB_EN
    input  lzb_on,
`endif
    output an, hex, dp, idx, frame_start
  );

endinterface

// File: rtl/seg_scan_pick.sv
// Masked round-robin next-index finder: first enabled digit after i_cur, wrapping.
module seg_scan_pick
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int IDXW     = idx_width(N_DIGITS)
) (
  input  logic [N_DIGITS-1:0] i_mask,
  input  logic [IDXW-1:0]     i_cur,
  output logic [IDXW-1:0]     o_next
);

  assign o_next = IDXW'(next_enabled(16'(i_mask), 4'(i_cur), N_DIGITS));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with hold time, blanking and digit mask.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int HOLD_TICKS = 1,
  parameter int DEAD_TICKS = 0
) (
  input logic            clk,
  input logic            rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDXW = idx_width(N_DIGITS);
  localparam int CNTW = idx_width(max_int(HOLD_TICKS, DEAD_TICKS));
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_TICKS - 1);
  localparam logic [CNTW-1:0] DEAD_LAST = CNTW'((DEAD_TICKS > 0) ? DEAD_TICKS - 1 : 0);
  localparam logic [IDXW-1:0] TOP_IDX   = IDXW'(N_DIGITS - 1);

  state_t                r_state, w_state_nxt;
  logic [CNTW-1:0]       r_cnt, w_cnt_nxt;
  logic                  r_boot;
  logic [IDXW-1:0]       r_idx;
  logic [N_DIGITS-1:0]   r_an;
  logic [3:0]            r_hex;
  logic                  r_dp;
  logic                  r_fs;

  logic [N_DIGITS-1:0]   w_supp, w_eff, w_mask, w_an_nxt;
  logic [IDXW-1:0]       w_next_idx, w_low_idx, w_enter_idx, w_show_idx;
  logic                  w_enter, w_fs_nxt, w_sel_dp;
  logic [3:0]            w_sel_hex;

`ifdef SEG_SCAN_LZB_EN
  logic                  w_zero_above;

  // A digit is suppressible only while it and every digit above it would show nothing.
  always_comb begin
    w_supp       = {N_DIGITS{1'b0}};
    w_zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (bus.digits[4*i +: 4] == 4'd0) & ~bus.dp_in[i];
      w_supp[i]    = bus.lzb_on & w_zero_above;
    end
  end
`else
  assign w_supp = {N_DIGITS{1'b0}};
`endif

  // Fall back to the raw mask if suppression would leave nothing to light.
  assign w_eff  = bus.digit_en & ~w_supp;
  assign w_mask = (|w_eff) ? w_eff : bus.digit_en;

  seg_scan_pick #(.N_DIGITS(N_DIGITS), .IDXW(IDXW)) u_pick_next (
    .i_mask (w_mask),
    .i_cur  (r_idx),
    .o_next (w_next_idx)
  );

  seg_scan_pick #(.N_DIGITS(N_DIGITS), .IDXW(IDXW)) u_pick_low (
    .i_mask (w_mask),
    .i_cur  (TOP_IDX),
    .o_next (w_low_idx)
  );

  // Next-state logic; a zero mask forces IDLE regardless of ce.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter     = 1'b0;
    w_enter_idx = r_idx;
    if (bus.digit_en == {N_DIGITS{1'b0}}) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = {CNTW{1'b0}};
    end else if (bus.ce) begin
      case (r_state)
        IDLE: begin
          w_enter     = 1'b1;
          w_enter_idx = w_low_idx;
        end
        BLANK: begin
          if (r_boot) begin
            w_enter     = 1'b1;
            w_enter_idx = w_low_idx;
          end else if (r_cnt == DEAD_LAST) begin
            w_enter     = 1'b1;
            w_enter_idx = w_next_idx;
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
        SHOW: begin
          if (r_cnt != HOLD_LAST) begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end else if (DEAD_TICKS > 0) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = {CNTW{1'b0}};
          end else begin
            w_enter     = 1'b1;
            w_enter_idx = w_next_idx;
          end
        end
        default: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = {CNTW{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    if (w_enter) begin
      w_state_nxt = SHOW;
      w_cnt_nxt   = {CNTW{1'b0}};
    end else begin
      w_cnt_nxt   = w_cnt_nxt;
    end
  end

  // Output data selection for the digit being entered and the next anode pattern.
  always_comb begin
    w_show_idx = w_enter ? w_enter_idx : r_idx;
    w_sel_hex  = 4'd0;
    w_sel_dp   = 1'b0;
    w_an_nxt   = {N_DIGITS{1'b1}};
    for (int i = 0; i < N_DIGITS; i++) begin
      w_sel_hex   = w_sel_hex | (bus.digits[4*i +: 4] & {4{w_enter_idx == IDXW'(i)}});
      w_sel_dp    = w_sel_dp | (bus.dp_in[i] & (w_enter_idx == IDXW'(i)));
      w_an_nxt[i] = ~((w_state_nxt == SHOW) && (w_show_idx == IDXW'(i)));
    end
    w_fs_nxt = w_enter & (w_enter_idx == w_low_idx);
  end

  // State, counter and registered outputs; hex/dp only load when a digit is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_cnt   <= {CNTW{1'b0}};
      r_boot  <= 1'b1;
      r_idx   <= {IDXW{1'b0}};
      r_an    <= {N_DIGITS{1'b1}};
      r_hex   <= 4'd0;
      r_dp    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_an    <= w_an_nxt;
      r_fs    <= w_fs_nxt;
      if (w_enter) begin
        r_idx  <= w_enter_idx;
        r_hex  <= w_sel_hex;
        r_dp   <= w_sel_dp;
        r_boot <= 1'b0;
      end
    end
  end

  assign bus.an          = r_an;
  assign bus.hex         = r_hex;
  assign bus.dp          = r_dp;
  assign bus.idx         = r_idx;
  assign bus.frame_start = r_fs;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected display events are queued by the
// stimulus, and monitors pop and compare whenever the anode pattern changes.
module tb_seg_scan_ctrl;

  typedef struct {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
    logic [1:0] idx;
    logic       fs;
    int         hold;
  } exp_t;

  logic clk;
  logic rst_a_n, rst_b_n;
  logic mon_a, mon_b;
  int   n_checks, n_fails;
  exp_t q_a[$];
  exp_t q_b[$];

  seg_scan_ctrl_if #(.N_DIGITS(4)) bus_a ();
  seg_scan_ctrl_if #(.N_DIGITS(4)) bus_b ();

  seg_scan_ctrl #(.N_DIGITS(4), .HOLD_TICKS(1), .DEAD_TICKS(0)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a));

  seg_scan_ctrl #(.N_DIGITS(4), .HOLD_TICKS(2), .DEAD_TICKS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] an, input logic [3:0] hex, input logic dp,
                              input logic [1:0] idx, input logic fs, input int hold);
    exp_t e;
    e.an = an; e.hex = hex; e.dp = dp; e.idx = idx; e.fs = fs; e.hold = hold;
    return e;
  endfunction

  function automatic logic [15:0] pk(input exp_t e);
    return {4'd0, e.an, e.hex, e.dp, e.idx, e.fs};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor for DUT a
  initial begin
    logic [3:0] prev;
    int run, hold;
    exp_t e, got;
    prev = 4'hF; run = 0; hold = 0;
    forever begin
      @(negedge clk);
      if (!mon_a) begin
        prev = bus_a.an; run = 0; hold = 0;
      end else if (bus_a.an != prev) begin
        if (hold != 0) chk("hold_a", 16'(run), 16'(hold));
        prev = bus_a.an; run = 1;
        got = mk(bus_a.an, bus_a.hex, bus_a.dp, bus_a.idx, bus_a.frame_start, 0);
        if (q_a.size() == 0) begin
          chk("unexpected_a", pk(got), 16'hFFFF);
          hold = 0;
        end else begin
          e = q_a.pop_front();
          chk("evt_a", pk(got), pk(e));
          hold = e.hold;
        end
      end else begin
        run++;
      end
    end
  end

  // Monitor for DUT b
  initial begin
    logic [3:0] prev;
    int run, hold;
    exp_t e, got;
    prev = 4'hF; run = 0; hold = 0;
    forever begin
      @(negedge clk);
      if (!mon_b) begin
        prev = bus_b.an; run = 0; hold = 0;
      end else if (bus_b.an != prev) begin
        if (hold != 0) chk("hold_b", 16'(run), 16'(hold));
        prev = bus_b.an; run = 1;
        got = mk(bus_b.an, bus_b.hex, bus_b.dp, bus_b.idx, bus_b.frame_start, 0);
        if (q_b.size() == 0) begin
          chk("unexpected_b", pk(got), 16'hFFFF);
          hold = 0;
        end else begin
          e = q_b.pop_front();
          chk("evt_b", pk(got), pk(e));
          hold = e.hold;
        end
      end else begin
        run++;
      end
    end
  end

  // ce for DUT b: high every second clock
  initial begin
    bus_b.ce = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus_b.ce = ~bus_b.ce;
    end
  end

  task automatic setup_a(input logic [15:0] dig, input logic [3:0] dpi, input logic [3:0] en);
    mon_a = 1'b0;
    rst_a_n = 1'b0;
    bus_a.digits = dig; bus_a.dp_in = dpi; bus_a.digit_en = en;
    step(1);
  endtask

  task automatic run_a(input int n);
    rst_a_n = 1'b1;
    mon_a = 1'b1;
    step(n);
    mon_a = 1'b0;
    chk("drain_a", 16'(q_a.size()), 16'd0);
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    mon_a = 1'b0; mon_b = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.ce = 1'b1;
    bus_a.digits = 16'h0000; bus_a.dp_in = 4'h0; bus_a.digit_en = 4'hF;
    bus_b.digits = 16'h3A5C; bus_b.dp_in = 4'b0010; bus_b.digit_en = 4'hF;
`ifdef SEG_SCAN_LZB_EN
    bus_a.lzb_on = 1'b0;
    bus_b.lzb_on = 1'b0;
`endif
    step(2);
    chk("reset_a", {4'd0, bus_a.an, bus_a.hex, bus_a.dp, bus_a.idx, bus_a.frame_start}, 16'h0F00);
    chk("reset_b", {4'd0, bus_b.an, bus_b.hex, bus_b.dp, bus_b.idx, bus_b.frame_start}, 16'h0F00);

    // Full rotation, two frames plus one
    setup_a(16'h4321, 4'b1000, 4'b1111);
    for (int i = 0; i < 9; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (i % 4);
      q_a.push_back(mk(~oh, 4'(i % 4 + 1), (i % 4) == 3, 2'(i % 4), (i % 4) == 0, (i < 8) ? 1 : 0));
    end
    run_a(10);

    // Sparse mask, then empty mask, then restored mask
    setup_a(16'h4321, 4'b0000, 4'b1010);
    q_a.push_back(mk(4'b1101, 4'h2, 1'b0, 2'd1, 1'b1, 1));
    q_a.push_back(mk(4'b0111, 4'h4, 1'b0, 2'd3, 1'b0, 1));
    q_a.push_back(mk(4'b1101, 4'h2, 1'b0, 2'd1, 1'b1, 1));
    q_a.push_back(mk(4'b0111, 4'h4, 1'b0, 2'd3, 1'b0, 1));
    q_a.push_back(mk(4'b1111, 4'h4, 1'b0, 2'd3, 1'b0, 3));
    q_a.push_back(mk(4'b1101, 4'h2, 1'b0, 2'd1, 1'b1, 1));
    q_a.push_back(mk(4'b0111, 4'h4, 1'b0, 2'd3, 1'b0, 0));
    rst_a_n = 1'b1; mon_a = 1'b1;
    step(4);
    bus_a.digit_en = 4'b0000;
    step(3);
    bus_a.digit_en = 4'b1010;
    step(3);
    mon_a = 1'b0;
    chk("drain_a", 16'(q_a.size()), 16'd0);

    // Digits change while digit 2 is lit
    setup_a(16'h4321, 4'b0000, 4'b1111);
    q_a.push_back(mk(4'b1110, 4'h1, 1'b0, 2'd0, 1'b1, 1));
    q_a.push_back(mk(4'b1101, 4'h2, 1'b0, 2'd1, 1'b0, 1));
    q_a.push_back(mk(4'b1011, 4'h3, 1'b0, 2'd2, 1'b0, 1));
    q_a.push_back(mk(4'b0111, 4'h8, 1'b0, 2'd3, 1'b0, 1));
    q_a.push_back(mk(4'b1110, 4'h5, 1'b0, 2'd0, 1'b1, 0));
    rst_a_n = 1'b1; mon_a = 1'b1;
    step(3);
    bus_a.digits = 16'h8765;
    step(3);
    mon_a = 1'b0;
    chk("drain_a", 16'(q_a.size()), 16'd0);

    // Asynchronous reset mid-SHOW
    setup_a(16'h4321, 4'b0000, 4'b1111);
    q_a.push_back(mk(4'b1110, 4'h1, 1'b0, 2'd0, 1'b1, 1));
    q_a.push_back(mk(4'b1101, 4'h2, 1'b0, 2'd1, 1'b0, 0));
    rst_a_n = 1'b1; mon_a = 1'b1;
    step(2);
    #4;
    mon_a = 1'b0;
    rst_a_n = 1'b0;
    #1;
    chk("async_rst", {4'd0, bus_a.an, bus_a.hex, bus_a.dp, bus_a.idx, bus_a.frame_start}, 16'h0F00);
    chk("drain_a", 16'(q_a.size()), 16'd0);

`ifdef SEG_SCAN_LZB_EN
    // Leading-zero blanking
    bus_a.lzb_on = 1'b1;
    setup_a(16'h0070, 4'b0000, 4'b1111);
    q_a.push_back(mk(4'b1110, 4'h0, 1'b0, 2'd0, 1'b1, 1));
    q_a.push_back(mk(4'b1101, 4'h7, 1'b0, 2'd1, 1'b0, 1));
    q_a.push_back(mk(4'b1110, 4'h0, 1'b0, 2'd0, 1'b1, 1));
    q_a.push_back(mk(4'b1101, 4'h7, 1'b0, 2'd1, 1'b0, 1));
    q_a.push_back(mk(4'b1110, 4'h0, 1'b0, 2'd0, 1'b1, 0));
    rst_a_n = 1'b1; mon_a = 1'b1;
    step(4);
    bus_a.digits = 16'h0000;
    step(3);
    chk("lzb_only0", {8'd0, bus_a.an, bus_a.hex}, {8'd0, 4'b1110, 4'h0});
    mon_a = 1'b0;
    chk("drain_a", 16'(q_a.size()), 16'd0);
    bus_a.lzb_on = 1'b0;
`endif

    // Hold and blanking timing on DUT b
    q_b.push_back(mk(4'b1110, 4'hC, 1'b0, 2'd0, 1'b1, 4));
    q_b.push_back(mk(4'b1111, 4'hC, 1'b0, 2'd0, 1'b0, 2));
    q_b.push_back(mk(4'b1101, 4'h5, 1'b1, 2'd1, 1'b0, 4));
    q_b.push_back(mk(4'b1111, 4'h5, 1'b1, 2'd1, 1'b0, 2));
    q_b.push_back(mk(4'b1011, 4'hA, 1'b0, 2'd2, 1'b0, 4));
    q_b.push_back(mk(4'b1111, 4'hA, 1'b0, 2'd2, 1'b0, 2));
    q_b.push_back(mk(4'b0111, 4'h3, 1'b0, 2'd3, 1'b0, 4));
    q_b.push_back(mk(4'b1111, 4'h3, 1'b0, 2'd3, 1'b0, 2));
    q_b.push_back(mk(4'b1110, 4'hC, 1'b0, 2'd0, 1'b1, 0));
    rst_b_n = 1'b1; mon_b = 1'b1;
    step(28);
    mon_b = 1'b0;
    chk("drain_b", 16'(q_b.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
